// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage in front of a combinational instruction
// memory.
//
// The stage owns the PC and presents it as the fetch address. It takes the
// instruction returned in the same cycle and registers {pc, instr, pc+4} into
// an IF/ID register. Decode consumes that register through a valid/ready
// handshake. Redirects reload the PC and flush IF/ID. A misaligned redirect
// target, or a PC beyond the end of the memory, raises a fetch fault and
// parks the stage in HALT until an aligned redirect arrives.
//
// Optional feature: define IF_PERF_EN to add the fetch and flush performance
// counters. Both counters are 32 bits wide and wrap.
//
// Parameters
//   RESET_PC      PC loaded on reset
//   MEM_WORDS     instruction memory depth in words (legal PC < MEM_WORDS*4)
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous reset, active-high
//   imem_addr_o   fetch address (= pc), combinational
//   imem_instr_i  instruction returned for imem_addr_o
//   redirect_i    taken branch/jump: load redirect_pc_i, flush IF/ID
//   redirect_pc_i redirect target
//   id_ready_i    decode accepts IF/ID this cycle
//   id_valid_o    IF/ID holds a valid instruction
//   id_pc_o       PC of the IF/ID instruction
//   id_pc4_o      id_pc_o + 4
//   id_instr_o    IF/ID instruction
//   fault_o       fetch fault (misaligned redirect or PC out of range)
//   fetch_cnt_o   (IF_PERF_EN) number of instructions fetched
//   flush_cnt_o   (IF_PERF_EN) number of valid IF/ID entries killed by redirect
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic [31:0] id_instr_o,
    output logic        fault_o
`ifdef IF_PERF_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg;

    logic aligned;
    logic oor;
    logic stall;
    logic advance;
    logic pc_load;
    logic fault_set;
    logic fault_clr;
    logic flush;

    assign imem_addr_o = pc_reg;
    assign aligned     = (redirect_pc_i[1:0] == 2'b00);
    assign oor         = ({2'b00, pc_reg[31:2]} >= 32'(MEM_WORDS));
    assign stall       = id_valid_o & ~id_ready_i;
    assign advance     = (state_reg == RUN) & ~stall & ~redirect_i & ~oor;

    // Next-state and control decode. Redirect outranks both the stall and
    // the out-of-range check, so a redirect always kills the IF/ID entry
    // even when decode is accepting it in the same cycle.
    always_comb begin
        state_next = state_reg;
        pc_load    = 1'b0;
        fault_set  = 1'b0;
        fault_clr  = 1'b0;
        flush      = 1'b0;
        case (state_reg)
            BOOT: begin
                state_next = RUN;
                // IF/ID is already empty during BOOT, so there is nothing to flush.
                if (redirect_i && aligned) begin
                    pc_load = 1'b1;
                end
            end
            RUN: begin
                if (redirect_i) begin
                    flush = 1'b1;
                    if (aligned) begin
                        pc_load = 1'b1;
                    end else begin
                        fault_set  = 1'b1;
                        state_next = HALT;
                    end
                end else if (oor) begin
                    flush      = 1'b1;
                    fault_set  = 1'b1;
                    state_next = HALT;
                end
            end
            HALT: begin
                // A misaligned redirect is ignored here; only an aligned
                // redirect can restart fetching.
                if (redirect_i && aligned) begin
                    pc_load    = 1'b1;
                    fault_clr  = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_reg     <= RESET_PC;
            id_valid_o <= 1'b0;
            id_pc_o    <= 32'h0;
            id_pc4_o   <= 32'h0;
            id_instr_o <= NOP;
            fault_o    <= 1'b0;
        end else begin
            if (pc_load) begin
                pc_reg <= redirect_pc_i;
            end else if (advance) begin
                pc_reg <= pc_reg + 32'd4;
            end

            if (flush) begin
                id_valid_o <= 1'b0;
            end else if (advance) begin
                id_valid_o <= 1'b1;
            end

            if (advance) begin
                id_pc_o    <= pc_reg;
                id_pc4_o   <= pc_reg + 32'd4;
                id_instr_o <= imem_instr_i;
            end

            if (fault_set) begin
                fault_o <= 1'b1;
            end else if (fault_clr) begin
                fault_o <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_o <= 32'h0;
            flush_cnt_o <= 32'h0;
        end else begin
            if (advance) begin
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
            // Only count redirects that actually discard a live instruction.
            if (redirect_i && (state_reg == RUN) && id_valid_o) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// DUT a (MEM_WORDS=64) is compared every cycle against a behavioural model.
// The bench drives it with directed scenarios followed by random stimulus.
// DUT b (MEM_WORDS=4) runs alongside it with ready held high. This lets the
// bench observe the end-of-memory fault.
// Both instruction memories return word index (addr/4) for any address.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam int MW = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] rpc;
    logic        ready;

    logic [31:0] addr_a, instr_a, pc_a, pc4_a, ins_a;
    logic        valid_a, fault_a;
    logic [31:0] addr_b, instr_b, pc_b, pc4_b, ins_b;
    logic        valid_b, fault_b;
`ifdef IF_PERF_EN
    logic [31:0] fcnt_a, flcnt_a, fcnt_b, flcnt_b;
`endif

    always #5 clk = ~clk;

    assign instr_a = addr_a >> 2;
    assign instr_b = addr_b >> 2;

    if_stage #(.RESET_PC(32'h0), .MEM_WORDS(MW)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .imem_addr_o(addr_a), .imem_instr_i(instr_a),
        .redirect_i(redirect), .redirect_pc_i(rpc),
        .id_ready_i(ready), .id_valid_o(valid_a),
        .id_pc_o(pc_a), .id_pc4_o(pc4_a), .id_instr_o(ins_a),
        .fault_o(fault_a)
`ifdef IF_PERF_EN
        , .fetch_cnt_o(fcnt_a), .flush_cnt_o(flcnt_a)
`endif
    );

    if_stage #(.RESET_PC(32'h0), .MEM_WORDS(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .imem_addr_o(addr_b), .imem_instr_i(instr_b),
        .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .id_ready_i(1'b1), .id_valid_o(valid_b),
        .id_pc_o(pc_b), .id_pc4_o(pc4_b), .id_instr_o(ins_b),
        .fault_o(fault_b)
`ifdef IF_PERF_EN
        , .fetch_cnt_o(fcnt_b), .flush_cnt_o(flcnt_b)
`endif
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Behavioural model of DUT a: mode 0=boot, 1=run, 2=halt
    int          m_mode;
    logic [31:0] m_pc, m_idpc, m_idpc4, m_instr;
    logic        m_valid, m_fault;
    logic [31:0] m_fetch, m_flush;

    task automatic model_reset();
        m_mode = 0; m_pc = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
        m_idpc = 32'h0; m_idpc4 = 32'h0; m_instr = 32'h13;
        m_fetch = 32'h0; m_flush = 32'h0;
    endtask

    task automatic model_step();
        bit ok_target;
        ok_target = (rpc % 4 == 0);
        if (m_mode == 0) begin
            if (redirect && ok_target) m_pc = rpc;
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (redirect) begin
                if (m_valid) m_flush = m_flush + 1;
                m_valid = 1'b0;
                if (ok_target) m_pc = rpc;
                else begin m_fault = 1'b1; m_mode = 2; end
            end else if (m_pc / 4 >= MW) begin
                m_valid = 1'b0; m_fault = 1'b1; m_mode = 2;
            end else if (!(m_valid && !ready)) begin
                m_idpc  = m_pc;
                m_idpc4 = m_pc + 4;
                m_instr = m_pc / 4;
                m_valid = 1'b1;
                m_pc    = m_pc + 4;
                m_fetch = m_fetch + 1;
            end
        end else begin
            if (redirect && ok_target) begin
                m_pc = rpc; m_fault = 1'b0; m_mode = 1;
            end
        end
    endtask

    task automatic compare_a();
        check("addr", addr_a, m_pc);
        check("valid", 32'(valid_a), 32'(m_valid));
        check("fault", 32'(fault_a), 32'(m_fault));
        if (m_valid) begin
            check("id_pc", pc_a, m_idpc);
            check("id_pc4", pc4_a, m_idpc4);
            check("id_instr", ins_a, m_instr);
        end
`ifdef IF_PERF_EN
        check("fetch_cnt", fcnt_a, m_fetch);
        check("flush_cnt", flcnt_a, m_flush);
`endif
    endtask

    // DUT b expectations after the n-th edge following reset release
    bit b_on = 1'b0;
    int b_cyc = 0;

    task automatic check_b();
        bit exp_v;
        b_cyc++;
        exp_v = (b_cyc >= 2 && b_cyc <= 5);
        check("b_valid", 32'(valid_b), 32'(exp_v));
        check("b_fault", 32'(fault_b), 32'(b_cyc >= 6));
        if (exp_v) begin
            check("b_pc", pc_b, 32'((b_cyc - 2) * 4));
            check("b_instr", ins_b, 32'(b_cyc - 2));
        end
        if (b_cyc >= 6) check("b_addr", addr_b, 32'h10);
        if (b_cyc == 8) b_on = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_a();
        if (b_on) check_b();
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; rpc = 32'h0; ready = 1'b1;
        model_reset();
        @(negedge clk);
        compare_a();
        check("rst_instr", ins_a, 32'h13);
        check("rst_b_valid", 32'(valid_b), 32'h0);
        rst = 1'b0;
        b_on = 1'b1;

        // streaming from address 0
        cycle(); check("boot_valid", 32'(valid_a), 32'h0);
        cycle(); check("first_valid", 32'(valid_a), 32'h1);
                 check("first_pc", pc_a, 32'h0); check("first_instr", ins_a, 32'h0);
        cycle(); check("s_pc4", pc_a, 32'h4); check("s_instr1", ins_a, 32'h1);
        cycle(); check("s_pc8", pc_a, 32'h8); check("s_addr12", addr_a, 32'hc);

        // stall
        ready = 1'b0;
        repeat (3) begin
            cycle(); check("stall_pc", pc_a, 32'h8); check("stall_addr", addr_a, 32'hc);
        end
        ready = 1'b1;
        cycle(); check("unstall_pc", pc_a, 32'hc);

        // aligned redirect
        redirect = 1'b1; rpc = 32'h40;
        cycle(); check("redir_valid", 32'(valid_a), 32'h0); check("redir_addr", addr_a, 32'h40);
        redirect = 1'b0;
        cycle(); check("redir_pc", pc_a, 32'h40); check("redir_pc4", pc4_a, 32'h44);

        // misaligned redirect -> HALT
        redirect = 1'b1; rpc = 32'h42;
        cycle(); check("mis_fault", 32'(fault_a), 32'h1); check("mis_valid", 32'(valid_a), 32'h0);
        rpc = 32'h47;
        cycle(); check("halt_ign_addr", addr_a, 32'h44); check("halt_fault", 32'(fault_a), 32'h1);
        redirect = 1'b0;
        cycle(); check("halt_valid", 32'(valid_a), 32'h0);
        redirect = 1'b1; rpc = 32'h80;
        cycle(); check("resume_fault", 32'(fault_a), 32'h0); check("resume_addr", addr_a, 32'h80);
        redirect = 1'b0;
        cycle(); check("resume_pc", pc_a, 32'h80); check("resume_valid", 32'(valid_a), 32'h1);

        // asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(valid_a), 32'h0);
        check("arst_instr", ins_a, 32'h13);
        check("arst_pc", pc_a, 32'h0);
        check("arst_pc4", pc4_a, 32'h0);
        check("arst_fault", 32'(fault_a), 32'h0);
        check("arst_addr", addr_a, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // 5 fetches then one flush of a valid entry
        repeat (6) cycle();
        redirect = 1'b1; rpc = 32'h20;
        cycle();
        redirect = 1'b0;
`ifdef IF_PERF_EN
        check("perf_fetch5", fcnt_a, 32'd5);
        check("perf_flush1", flcnt_a, 32'd1);
`endif

        // random phase
        repeat (600) begin
            redirect = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0, 1: rpc = 32'($urandom_range(0, MW - 1)) * 4;
                2:    rpc = 32'($urandom_range(MW - 4, MW + 8)) * 4;
                default: rpc = 32'($urandom_range(0, MW - 1)) * 4 + 32'($urandom_range(1, 3));
            endcase
            ready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
